// File: rtl/grid_sweep_ctrl.sv
// grid_sweep_ctrl: owns the paper grid, streams it in row by row, then commits
// the external sweep datapath result each cycle until a sweep removes nothing.
module grid_sweep_ctrl #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 16,
    parameter int MAX_SWEEPS = 256,
    localparam int CW        = $clog2(WIDTH*DEPTH+1),
    localparam int SW        = $clog2(MAX_SWEEPS+1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   row_valid,
    input  logic [WIDTH-1:0]       row_data,
    output logic                   row_ready,
    output logic [WIDTH*DEPTH-1:0] dp_grid,
    input  logic [WIDTH*DEPTH-1:0] dp_grid_next,
    input  logic [CW-1:0]          dp_removed,
    input  logic                   dp_any,
    output logic                   busy,
    output logic                   done,
    output logic [CW-1:0]          first_count,
    output logic [CW-1:0]          total_count,
    output logic [SW-1:0]          sweeps,
    output logic                   timeout
);

    localparam int RW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, SWEEP, DONE} state_t;

    state_t                   state, state_next;
    logic [WIDTH*DEPTH-1:0]   grid;
    logic [RW-1:0]            row_idx;
    logic [SW-1:0]            sweeps_inc;
    logic                     accept_start;
    logic                     load_row;
    logic                     commit;
    logic                     budget_hit;
    logic                     enter_done;

    assign dp_grid    = grid;
    assign sweeps_inc = sweeps + 1'b1;
    assign budget_hit = (sweeps_inc == SW'(MAX_SWEEPS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        row_ready    = 1'b0;
        busy         = 1'b0;
        accept_start = 1'b0;
        load_row     = 1'b0;
        commit       = 1'b0;
        enter_done   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept_start = 1'b1;
                    state_next   = LOAD;
                end
            end
            LOAD: begin
                row_ready = 1'b1;
                busy      = 1'b1;
                if (row_valid) begin
                    load_row = 1'b1;
                    if (row_idx == RW'(DEPTH-1)) begin
                        state_next = SWEEP;
                    end
                end
            end
            SWEEP: begin
                busy = 1'b1;
                // dp_any alone decides control; dp_removed is only accumulated
                if (dp_any) begin
                    commit = 1'b1;
                    if (budget_hit) begin
                        enter_done = 1'b1;
                        state_next = DONE;
                    end
                end else begin
                    enter_done = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grid        <= '0;
            row_idx     <= '0;
            first_count <= '0;
            total_count <= '0;
            sweeps      <= '0;
            timeout     <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= enter_done;
            if (accept_start) begin
                grid        <= '0;
                row_idx     <= '0;
                first_count <= '0;
                total_count <= '0;
                sweeps      <= '0;
                timeout     <= 1'b0;
            end
            if (load_row) begin
                grid[int'(row_idx)*WIDTH +: WIDTH] <= row_data;
                row_idx                            <= row_idx + 1'b1;
            end
            if (commit) begin
                grid        <= dp_grid_next;
                total_count <= total_count + dp_removed;
                sweeps      <= sweeps_inc;
                if (sweeps == '0) begin
                    first_count <= dp_removed;
                end
                if (budget_hit) begin
                    timeout <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_grid_sweep_ctrl.sv
// tb_grid_sweep_ctrl: drives two 4x4 controllers (budgets 256 and 2) with a
// behavioural sweep datapath and checks them every cycle against a job-level model.
module tb_grid_sweep_ctrl;

    localparam int W = 4;
    localparam int D = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, row_valid;
    logic [3:0]  row_data;

    logic        ready_a, busy_a, done_a, any_a, to_a;
    logic [15:0] grid_a, nxt_a;
    logic [4:0]  rem_a, first_a, total_a;
    logic [8:0]  sweeps_a;

    logic        ready_b, busy_b, done_b, any_b, to_b;
    logic [15:0] grid_b, nxt_b;
    logic [4:0]  rem_b, first_b, total_b;
    logic [1:0]  sweeps_b;

    int na, nb;

    int o_ready[2], o_busy[2], o_done[2], o_first[2];
    int o_total[2], o_sweeps[2], o_to[2], o_grid[2];

    int          m_L;
    int          m_k[2];
    int          m_to[2];
    int          m_done[2];
    logic [15:0] m_grid[2][21];
    int          m_rem[2][21];
    int          stall_pat[4];
    int          cyc;
    bit          job_on;
    int          tests;
    int          errors;

    grid_sweep_ctrl #(.WIDTH(W), .DEPTH(D), .MAX_SWEEPS(256)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .row_valid(row_valid),
        .row_data(row_data), .row_ready(ready_a), .dp_grid(grid_a),
        .dp_grid_next(nxt_a), .dp_removed(rem_a), .dp_any(any_a),
        .busy(busy_a), .done(done_a), .first_count(first_a),
        .total_count(total_a), .sweeps(sweeps_a), .timeout(to_a)
    );

    grid_sweep_ctrl #(.WIDTH(W), .DEPTH(D), .MAX_SWEEPS(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .row_valid(row_valid),
        .row_data(row_data), .row_ready(ready_b), .dp_grid(grid_b),
        .dp_grid_next(nxt_b), .dp_removed(rem_b), .dp_any(any_b),
        .busy(busy_b), .done(done_b), .first_count(first_b),
        .total_count(total_b), .sweeps(sweeps_b), .timeout(to_b)
    );

    // A roll is removed when fewer than four of its eight neighbours hold paper.
    function automatic logic [15:0] sweep_once(input logic [15:0] g, output int removed);
        logic [15:0] n;
        int cnt, rr, cc;
        n = g;
        removed = 0;
        for (int r = 0; r < D; r++) begin
            for (int c = 0; c < W; c++) begin
                if (g[r*W+c]) begin
                    cnt = 0;
                    for (int dr = -1; dr <= 1; dr++) begin
                        for (int dc = -1; dc <= 1; dc++) begin
                            rr = r + dr;
                            cc = c + dc;
                            if (!(dr == 0 && dc == 0) && rr >= 0 && rr < D && cc >= 0 && cc < W) begin
                                if (g[rr*W+cc]) cnt++;
                            end
                        end
                    end
                    if (cnt < 4) begin
                        n[r*W+c] = 1'b0;
                        removed++;
                    end
                end
            end
        end
        return n;
    endfunction

    always_comb begin
        na    = 0;
        nxt_a = sweep_once(grid_a, na);
        rem_a = 5'(na);
        any_a = (na != 0);
    end

    always_comb begin
        nb    = 0;
        nxt_b = sweep_once(grid_b, nb);
        rem_b = 5'(nb);
        any_b = (nb != 0);
    end

    always_comb begin
        o_ready[0] = int'(ready_a);  o_ready[1] = int'(ready_b);
        o_busy[0]  = int'(busy_a);   o_busy[1]  = int'(busy_b);
        o_done[0]  = int'(done_a);   o_done[1]  = int'(done_b);
        o_first[0] = int'(first_a);  o_first[1] = int'(first_b);
        o_total[0] = int'(total_a);  o_total[1] = int'(total_b);
        o_sweeps[0]= int'(sweeps_a); o_sweeps[1]= int'(sweeps_b);
        o_to[0]    = int'(to_a);     o_to[1]    = int'(to_b);
        o_grid[0]  = int'(grid_a);   o_grid[1]  = int'(grid_b);
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int rem_sum(input int i, input int j);
        int s;
        s = 0;
        for (int q = 0; q < j; q++) s += m_rem[i][q];
        return s;
    endfunction

    // Whole-job outcome per instance: sweep sequence, final grid, done cycle.
    task automatic buildModel(input logic [15:0] g0);
        logic [15:0] g, nxt;
        int rem, k, budget;
        bit fin;
        m_L = D;
        for (int q = 0; q < D; q++) m_L += stall_pat[q];
        for (int i = 0; i < 2; i++) begin
            budget = (i == 0) ? 256 : 2;
            g = g0;
            k = 0;
            fin = 1'b0;
            m_to[i] = 0;
            m_grid[i][0] = g0;
            while (!fin) begin
                nxt = sweep_once(g, rem);
                if (rem == 0) begin
                    m_done[i] = m_L + k + 2;
                    fin = 1'b1;
                end else begin
                    m_rem[i][k] = rem;
                    k++;
                    m_grid[i][k] = nxt;
                    g = nxt;
                    if (k == budget) begin
                        m_to[i] = 1;
                        m_done[i] = m_L + k + 1;
                        fin = 1'b1;
                    end
                end
            end
            m_k[i] = k;
        end
    endtask

    always @(negedge clk) begin
        if (job_on) begin
            for (int i = 0; i < 2; i++) begin
                int j;
                string tag;
                tag = $sformatf("%s c%0d", (i == 0) ? "A" : "B", cyc);
                checkOutput({tag, " row_ready"}, o_ready[i], int'(cyc >= 1 && cyc <= m_L));
                checkOutput({tag, " busy"}, o_busy[i], int'(cyc >= 1 && cyc < m_done[i]));
                checkOutput({tag, " done"}, o_done[i], int'(cyc == m_done[i]));
                if (cyc >= 1 && cyc <= m_L) begin
                    checkOutput({tag, " first"}, o_first[i], 0);
                    checkOutput({tag, " total"}, o_total[i], 0);
                    checkOutput({tag, " sweeps"}, o_sweeps[i], 0);
                    checkOutput({tag, " timeout"}, o_to[i], 0);
                end else if (cyc > m_L && cyc < m_done[i]) begin
                    j = cyc - m_L - 1;
                    checkOutput({tag, " first"}, o_first[i], (j > 0) ? m_rem[i][0] : 0);
                    checkOutput({tag, " total"}, o_total[i], rem_sum(i, j));
                    checkOutput({tag, " sweeps"}, o_sweeps[i], j);
                    checkOutput({tag, " timeout"}, o_to[i], 0);
                    checkOutput({tag, " grid"}, o_grid[i], int'(m_grid[i][j]));
                end else if (cyc >= m_done[i]) begin
                    checkOutput({tag, " first"}, o_first[i], (m_k[i] > 0) ? m_rem[i][0] : 0);
                    checkOutput({tag, " total"}, o_total[i], rem_sum(i, m_k[i]));
                    checkOutput({tag, " sweeps"}, o_sweeps[i], m_k[i]);
                    checkOutput({tag, " timeout"}, o_to[i], m_to[i]);
                    checkOutput({tag, " grid"}, o_grid[i], int'(m_grid[i][m_k[i]]));
                end
            end
        end
    end

    task automatic checkAllZero(input string tag);
        for (int i = 0; i < 2; i++) begin
            checkOutput({tag, " row_ready"}, o_ready[i], 0);
            checkOutput({tag, " busy"}, o_busy[i], 0);
            checkOutput({tag, " done"}, o_done[i], 0);
            checkOutput({tag, " first"}, o_first[i], 0);
            checkOutput({tag, " total"}, o_total[i], 0);
            checkOutput({tag, " sweeps"}, o_sweeps[i], 0);
            checkOutput({tag, " timeout"}, o_to[i], 0);
            checkOutput({tag, " grid"}, o_grid[i], 0);
        end
    endtask

    // One job: start at cycle 0, rows per stall_pat, optional stray starts and reset abort.
    task automatic applyStimulus(input logic [15:0] g, input bit extra_start,
                                 input int abort_cyc, input int gap);
        int maxd, r, pend;
        maxd = (m_done[0] > m_done[1]) ? m_done[0] : m_done[1];
        r = 0;
        pend = stall_pat[0];
        @(posedge clk); #1;
        cyc = 0;
        start = 1'b1;
        row_valid = 1'b0;
        job_on = 1'b1;
        while (cyc < maxd + gap) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == abort_cyc) begin
                job_on = 1'b0;
                start = 1'b0;
                row_valid = 1'b0;
                rst_n = 1'b0;
                #1;
                checkAllZero("async reset");
                @(negedge clk);
                rst_n = 1'b1;
                @(posedge clk); #1;
                checkAllZero("after reset");
                return;
            end
            start = extra_start && (cyc == 2 || cyc == m_L + 1);
            row_data = 4'($urandom);
            row_valid = 1'b0;
            if (r < D) begin
                if (pend > 0) begin
                    pend--;
                end else begin
                    row_valid = 1'b1;
                    row_data = g[r*W +: W];
                    r++;
                    if (r < D) pend = stall_pat[r];
                end
            end
        end
        @(negedge clk); #1;
    endtask

    initial begin
        tests = 0;
        errors = 0;
        job_on = 1'b0;
        cyc = 0;
        rst_n = 1'b0;
        start = 1'b0;
        row_valid = 1'b0;
        row_data = '0;
        for (int q = 0; q < D; q++) stall_pat[q] = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkAllZero("reset");

        buildModel(16'h0000);
        checkOutput("model zero done", m_done[0], 6);
        checkOutput("model zero sweeps", m_k[0], 0);
        applyStimulus(16'h0000, 1'b0, -1, 1);

        buildModel(16'hFFFF);
        checkOutput("model full done", m_done[0], 7);
        checkOutput("model full first", m_rem[0][0], 4);
        checkOutput("model full sweeps", m_k[0], 1);
        checkOutput("model full grid", int'(m_grid[0][1]), 'h6FF6);
        applyStimulus(16'hFFFF, 1'b0, -1, 1);

        buildModel(16'h0777);
        checkOutput("model block sweeps", m_k[0], 3);
        checkOutput("model block total", rem_sum(0, 3), 9);
        checkOutput("model block done", m_done[0], 9);
        checkOutput("model block grid", int'(m_grid[0][3]), 0);
        checkOutput("model budget timeout", m_to[1], 1);
        checkOutput("model budget sweeps", m_k[1], 2);
        checkOutput("model budget total", rem_sum(1, 2), 8);
        checkOutput("model budget done", m_done[1], 7);
        checkOutput("model budget grid", int'(m_grid[1][2]), 'h0020);
        applyStimulus(16'h0777, 1'b0, -1, 0);

        stall_pat[2] = 2;
        buildModel(16'hFFFF);
        checkOutput("model stall done", m_done[0], 9);
        applyStimulus(16'hFFFF, 1'b1, -1, 1);

        stall_pat[2] = 0;
        buildModel(16'h0777);
        applyStimulus(16'h0777, 1'b0, m_L + 2, 0);
        applyStimulus(16'h0777, 1'b0, -1, 0);

        for (int t = 0; t < 30; t++) begin
            logic [15:0] g;
            g = 16'($urandom);
            if (t % 3 == 0) g = g | 16'($urandom);
            for (int q = 0; q < D; q++) stall_pat[q] = int'($urandom_range(0, 2));
            buildModel(g);
            applyStimulus(g, 1'($urandom_range(0, 1)), -1, int'($urandom_range(0, 2)));
        end

        job_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/grid_sweep_ctrl.md
# grid_sweep_ctrl

- Sequencer for the combinational single-sweep paper-removal datapath: it owns the grid state, loads the initial grid row by row through a valid/ready stream, and presents the registered grid to the datapath.
- Each cycle in which the datapath reports removals, it commits the returned grid and accumulates the removed count.
- It stops when a sweep removes nothing, or when a sweep budget is exhausted.
- It reports the first-sweep count, the total removal count and the number of productive sweeps.

## Interface

Parameters:
- WIDTH, 16, grid columns.
- DEPTH, 16, grid rows.
- MAX_SWEEPS, 256, budget of productive sweeps, ≥1.
- Derived: CW = $clog2(WIDTH*DEPTH+1); SW = $clog2(MAX_SWEEPS+1).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a job; sampled only in IDLE.
- row_valid  in  1  row_data valid.
- row_data  in  WIDTH  one grid row; bit c = column c; 1 = paper.
- row_ready  out  1  controller accepts a row.
- dp_grid  out  WIDTH*DEPTH  registered grid to the datapath; row r at [r*WIDTH +: WIDTH].
- dp_grid_next  in  WIDTH*DEPTH  datapath result, same packing.
- dp_removed  in  CW  cells removed by this sweep.
- dp_any  in  1  dp_removed != 0.
- busy  out  1  high in LOAD and SWEEP.
- done  out  1  one-cycle pulse at job end.
- first_count  out  CW  removed count of sweep 1.
- total_count  out  CW  sum over productive sweeps.
- sweeps  out  SW  number of productive sweeps.
- timeout  out  1  job ended on the budget, not on convergence.

## Operation

- States: IDLE, LOAD, SWEEP, DONE.
- **IDLE:**
  - row_ready=0.
  - On start=1: clear the grid, row index, first_count, total_count, sweeps and timeout; go to LOAD.
- **LOAD:**
  - row_ready=1.
  - On row_valid&&row_ready: grid[row_idx] <= row_data; row_idx++.
  - Rows arrive strictly in order, 0..DEPTH-1. row_valid gaps stall with no side effects.
  - Acceptance of row DEPTH-1 moves to SWEEP.
- **SWEEP:** each cycle the datapath evaluates dp_grid combinationally.
  - If dp_any=1:
    - grid <= dp_grid_next.
    - total_count += dp_removed.
    - If sweeps==0, first_count <= dp_removed.
    - sweeps++.
    - If the new sweeps value == MAX_SWEEPS, set timeout=1 and go to DONE.
  - If dp_any=0: grid is unchanged; go to DONE (convergence).
- **DONE:** done=1 for exactly this cycle, then IDLE.
- Results (counts, timeout, dp_grid) hold until the next accepted start.
- start in LOAD/SWEEP/DONE is ignored (no queueing).
- Arithmetic:
  - total_count cannot overflow, because total ≤ WIDTH*DEPTH by construction.
  - dp_removed is trusted. Inconsistency between dp_any and dp_removed is not checked; dp_any governs control.
- A job requiring exactly MAX_SWEEPS productive sweeps reports timeout=1. The budget check does not spend a terminating sweep.
- Reset (async, any state, including mid-LOAD/SWEEP):
  - state=IDLE.
  - grid, row_idx, counts and sweeps = 0.
  - row_ready, busy, done and timeout = 0.

## Timing

- All outputs are registered, except that row_ready and busy are decoded from state.
- Cycle 0: start sampled in IDLE.
- Cycle 1: LOAD, with row_ready=1.
- With back-to-back rows, rows are accepted in cycles 1..DEPTH and SWEEP begins at cycle DEPTH+1.
- With K productive sweeps and no timeout:
  - Convergence is detected at cycle DEPTH+K+1.
  - done=1 at cycle DEPTH+K+2.
  - Each sweep costs one cycle.
- With timeout, done is at cycle DEPTH+MAX_SWEEPS+1.
- Every stall cycle on row_valid adds one cycle.
- A start asserted in the cycle after DONE (state IDLE) is accepted.

## Test plan

- **All-zero grid, WIDTH=DEPTH=4, rows back-to-back.**
  - done at cycle 6.
  - first_count=0, total_count=0, sweeps=0, timeout=0.
- **Full grid, 4x4, all rows 4'b1111.**
  - Corners are removed in sweep 1.
  - first_count=4, total_count=4, sweeps=1, timeout=0, done at cycle 7.
  - Final grid rows: 0110, 1111, 1111, 0110.
- **3x3 block (rows 0111, 0111, 0111, 0000), MAX_SWEEPS=256.**
  - Sweeps remove 4, 4, 1.
  - first_count=4, total_count=9, sweeps=3, timeout=0, done at cycle 9.
  - Final grid all zero.
- **Same grid, MAX_SWEEPS=2.**
  - timeout=1, sweeps=2, total_count=8, done at cycle 7.
  - Final grid has only row1 bit1 set.
- **Full-grid case with row_valid deasserted 2 cycles between rows 1 and 2, plus start pulsed during LOAD.**
  - Same results as the full-grid case; done at cycle 9.
  - The extra start has no effect.
- **3x3 case with rst_n asserted during the second SWEEP cycle.**
  - All outputs are 0 immediately (asynchronous).
  - After release, IDLE with row_ready=0.
  - A new start then completes a normal 3x3 job.
